// File: rtl/fip_pkg.sv
// Shared definitions for the fixed-point intersection path.
// Holds the default Q16.16 format, vector/triangle/ray types, the
// intersection FSM state encoding, and the rescale/range-check helpers.
// The helpers use a wide signed container so that one function can serve
// any word width up to 64 bits.
package fip_pkg;

  localparam int unsigned FIP_W = 32;
  localparam int unsigned FIP_F = 16;
  localparam logic [FIP_W-1:0] FIP_ONE = {{(FIP_W-FIP_F-1){1'b0}}, 1'b1, {FIP_F{1'b0}}};

  typedef logic signed [FIP_W-1:0]   fix_t;
  typedef logic [0:2][FIP_W-1:0]     vec3_t;
  typedef logic [0:2][0:2][FIP_W-1:0] tri_t;
  typedef logic [0:1][0:2][FIP_W-1:0] ray_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUB,
    ST_DET,
    ST_DIV,
    ST_CHK,
    ST_OUT
  } fip_state_e;

  localparam int unsigned WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Drop F fraction bits; arithmetic shift truncates toward -infinity.
  function automatic wide_t rescale(input wide_t p, input int unsigned f);
    return p >>> f;
  endfunction

  // True when v is representable as a w-bit two's complement value.
  function automatic logic fits_signed(input wide_t v, input int unsigned w);
    wide_t s;
    s = v >>> (w - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/fip_seq_div.sv
// Sequential signed restoring divider producing (|num| << F) / |den| with
// the sign applied afterwards.
// Ports: clk, rst_n (async active-low); start (accepted only when idle);
// num, den (signed W-bit); busy (iterating); done (high during the last
// iteration cycle, when quot/ovf are valid); quot (signed W-bit result);
// ovf (quotient magnitude above 2^(W-1)-1).
// One division takes 1 load cycle plus W+F iteration cycles.
module fip_seq_div
  import fip_pkg::*;
#(
  parameter int unsigned W = FIP_W,
  parameter int unsigned F = FIP_F
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] num,
  input  logic signed [W-1:0] den,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] quot,
  output logic                ovf
);

  localparam int unsigned N  = W + F;
  localparam int unsigned CW = $clog2(N + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  dmag_q;
  logic [N-1:0]  dvd_q;
  logic          neg_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  num_mag;
  logic [W-1:0]  den_mag;
  logic [W:0]    rem_sh;
  logic [W-1:0]  rem_n;
  logic [N-1:0]  dvd_n;
  logic          ge;

  // dvd_q shifts dividend bits out at the top and quotient bits in at the
  // bottom, so after N steps it holds the full quotient.  The result is
  // taken from the step outputs so it is usable in the done cycle itself.
  always_comb begin
    num_mag = num[W-1] ? -num : num;
    den_mag = den[W-1] ? -den : den;
    rem_sh  = {rem_q, dvd_q[N-1]};
    ge      = rem_sh >= {1'b0, dmag_q};
    rem_n   = ge ? rem_sh[W-1:0] - dmag_q : rem_sh[W-1:0];
    dvd_n   = {dvd_q[N-2:0], ge};
    done    = busy && (cnt_q == CW'(1));
    ovf     = |dvd_n[N-1:W-1];
    quot    = neg_q ? -dvd_n[W-1:0] : dvd_n[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dmag_q <= '0;
      neg_q  <= 1'b0;
    end else if (busy) begin
      rem_q <= rem_n;
      dvd_q <= dvd_n;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      dvd_q  <= {num_mag, {F{1'b0}}};
      dmag_q <= den_mag;
      neg_q  <= num[W-1] ^ den[W-1];
      cnt_q  <= CW'(N);
      busy   <= 1'b1;
    end
  end

endmodule

// File: rtl/ray_tri_intersect_seq.sv
// Sequential ray/triangle intersection (Cramer's rule, signed fixed point).
// Ports: i_clk, i_rst_n (async active-low); i_valid/o_ready accept one
// triangle (V0..V2), ray (origin E, direction D) and tag i_id;
// o_valid/i_ready return o_hit, o_invalid, distance o_t, unnormalised
// normal o_normal = T1 x T2, and o_id.
// One determinant datapath is reused for den, a, b and t numerators, and
// one sequential divider produces a, b, t in turn.
module ray_tri_intersect_seq
  import fip_pkg::*;
#(
  parameter int unsigned          W             = FIP_W,
  parameter int unsigned          F             = FIP_F,
  parameter int unsigned          ID_W          = 8,
  parameter logic signed [W-1:0]  MIN_T         = '0,
  parameter logic signed [W-1:0]  MAX_T         = {1'b0, {(W-1){1'b1}}},
  parameter bit                   CULL_BACKFACE = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [0:2][0:2][W-1:0]   i_triangle,
  input  logic [0:1][0:2][W-1:0]   i_ray,
  input  logic [ID_W-1:0]          i_id,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_hit,
  output logic                     o_invalid,
  output logic [W-1:0]             o_t,
  output logic [0:2][W-1:0]        o_normal,
  output logic [ID_W-1:0]          o_id
);

  typedef logic signed [W-1:0] word_t;
  typedef logic [0:2][W-1:0]   vec_t;

  localparam logic signed [W:0] ONE_X = {{(W-F){1'b0}}, 1'b1, {F{1'b0}}};

  function automatic void mul_rs(input word_t x, input word_t y,
                                 output word_t r, output logic ovf);
    logic signed [2*W-1:0] p;
    wide_t s;
    p   = (2*W)'(x) * (2*W)'(y);
    s   = rescale(wide_t'(p), F);
    r   = s[W-1:0];
    ovf = !fits_signed(s, W);
  endfunction

  function automatic void sub_chk(input word_t a, input word_t b,
                                  output word_t r, output logic ovf);
    logic signed [W:0] diff;
    diff = (W+1)'(a) - (W+1)'(b);
    r    = diff[W-1:0];
    ovf  = !fits_signed(wide_t'(diff), W);
  endfunction

  function automatic void sub_vec(input vec_t a, input vec_t b,
                                  output vec_t r, output logic ovf);
    logic o0, o1, o2;
    sub_chk(a[0], b[0], r[0], o0);
    sub_chk(a[1], b[1], r[1], o1);
    sub_chk(a[2], b[2], r[2], o2);
    ovf = o0 | o1 | o2;
  endfunction

  // r = a*b - c*d with each product rescaled before the difference.
  function automatic void cross_term(input word_t a, input word_t b,
                                     input word_t c, input word_t d,
                                     output word_t r, output logic ovf);
    word_t p, q;
    logic op, oq;
    logic signed [W:0] diff;
    mul_rs(a, b, p, op);
    mul_rs(c, d, q, oq);
    diff = (W+1)'(p) - (W+1)'(q);
    r    = diff[W-1:0];
    ovf  = op | oq | !fits_signed(wide_t'(diff), W);
  endfunction

  function automatic void cross3(input vec_t u, input vec_t v,
                                 output vec_t r, output logic ovf);
    logic o0, o1, o2;
    cross_term(u[1], v[2], u[2], v[1], r[0], o0);
    cross_term(u[2], v[0], u[0], v[2], r[1], o1);
    cross_term(u[0], v[1], u[1], v[0], r[2], o2);
    ovf = o0 | o1 | o2;
  endfunction

  // det(c0,c1,c2) = c0 . (c1 x c2)
  function automatic void det3(input vec_t c0, input vec_t c1, input vec_t c2,
                               output word_t r, output logic ovf);
    vec_t x;
    logic ox, o0, o1, o2;
    word_t p0, p1, p2;
    logic signed [W+1:0] sum;
    cross3(c1, c2, x, ox);
    mul_rs(c0[0], x[0], p0, o0);
    mul_rs(c0[1], x[1], p1, o1);
    mul_rs(c0[2], x[2], p2, o2);
    sum = (W+2)'(p0) + (W+2)'(p1) + (W+2)'(p2);
    r   = sum[W-1:0];
    ovf = ox | o0 | o1 | o2 | !fits_signed(wide_t'(sum), W);
  endfunction

  fip_state_e state_q, state_d;

  logic [0:2][0:2][W-1:0] tri_q;
  logic [0:1][0:2][W-1:0] ray_q;
  logic [ID_W-1:0]        id_q;
  vec_t                   t1_q, t2_q, et_q, nd_q, normal_q;
  word_t                  den_q, anum_q, bnum_q, tnum_q;
  word_t                  qa_q, qb_q, qt_q;
  logic                   invalid_q, miss_q;
  logic [1:0]             det_idx_q, div_sel_q;

  vec_t              t1_d, t2_d, et_d, nd_d, normal_d;
  vec_t              c0, c1, c2;
  logic              ovf_t1, ovf_t2, ovf_et, ovf_nd, sub_ovf;
  logic              ovf_norm, det_ovf;
  word_t             det_val;
  logic signed [W:0] ab_sum;
  logic              hit_d;
  logic              den_cull, den_reject;

  logic  div_start, div_busy, div_done, div_ovf;
  word_t div_num, div_q;

  always_comb begin
    sub_vec(tri_q[1], tri_q[0], t1_d, ovf_t1);
    sub_vec(tri_q[2], tri_q[0], t2_d, ovf_t2);
    sub_vec(ray_q[0], tri_q[0], et_d, ovf_et);
    sub_vec('0,       ray_q[1], nd_d, ovf_nd);
    sub_ovf = ovf_t1 | ovf_t2 | ovf_et | ovf_nd;

    cross3(t1_q, t2_q, normal_d, ovf_norm);

    c0 = t1_q;
    c1 = t2_q;
    c2 = nd_q;
    unique case (det_idx_q)
      2'd0:    begin c0 = t1_q; c1 = t2_q; c2 = nd_q; end
      2'd1:    begin c0 = et_q; c1 = t2_q; c2 = nd_q; end
      2'd2:    begin c0 = t1_q; c1 = et_q; c2 = nd_q; end
      default: begin c0 = t1_q; c1 = t2_q; c2 = et_q; end
    endcase
    det3(c0, c1, c2, det_val, det_ovf);

    den_cull   = CULL_BACKFACE && (den_q[W-1] || (den_q == '0));
    den_reject = den_cull || (den_q == '0);

    ab_sum = (W+1)'(qa_q) + (W+1)'(qb_q);
    hit_d  = !invalid_q && !miss_q && !qa_q[W-1] && !qb_q[W-1] &&
             (ab_sum <= ONE_X) && (qt_q >= MIN_T) && (qt_q <= MAX_T);

    unique case (div_sel_q)
      2'd0:    div_num = anum_q;
      2'd1:    div_num = bnum_q;
      default: div_num = tnum_q;
    endcase
  end

  fip_seq_div #(
    .W (W),
    .F (F)
  ) u_div (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (den_q),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_q),
    .ovf   (div_ovf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = ST_SUB;
      end
      ST_SUB: state_d = ST_DET;
      ST_DET: if (det_idx_q == 2'd3) state_d = den_reject ? ST_CHK : ST_DIV;
      ST_DIV: begin
        div_start = !div_busy;
        if (div_done && (div_sel_q == 2'd2)) state_d = ST_CHK;
      end
      ST_CHK: state_d = ST_OUT;
      ST_OUT: begin
        o_valid = 1'b1;
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tri_q     <= '0;
      ray_q     <= '0;
      id_q      <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      et_q      <= '0;
      nd_q      <= '0;
      normal_q  <= '0;
      den_q     <= '0;
      anum_q    <= '0;
      bnum_q    <= '0;
      tnum_q    <= '0;
      qa_q      <= '0;
      qb_q      <= '0;
      qt_q      <= '0;
      invalid_q <= 1'b0;
      miss_q    <= 1'b0;
      det_idx_q <= '0;
      div_sel_q <= '0;
      o_hit     <= 1'b0;
      o_invalid <= 1'b0;
      o_t       <= '0;
      o_normal  <= '0;
      o_id      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (i_valid) begin
          tri_q     <= i_triangle;
          ray_q     <= i_ray;
          id_q      <= i_id;
          invalid_q <= 1'b0;
          miss_q    <= 1'b0;
          det_idx_q <= '0;
          div_sel_q <= '0;
        end
        ST_SUB: begin
          t1_q      <= t1_d;
          t2_q      <= t2_d;
          et_q      <= et_d;
          nd_q      <= nd_d;
          invalid_q <= invalid_q | sub_ovf;
        end
        ST_DET: begin
          det_idx_q <= det_idx_q + 2'd1;
          unique case (det_idx_q)
            2'd0:    den_q  <= det_val;
            2'd1:    anum_q <= det_val;
            2'd2:    bnum_q <= det_val;
            default: tnum_q <= det_val;
          endcase
          if (det_idx_q == 2'd0) normal_q <= normal_d;
          // Last DET cycle also applies the denominator verdict: culled
          // back faces are a clean miss, a zero den is invalid.
          invalid_q <= invalid_q | det_ovf |
                       ((det_idx_q == 2'd0) && ovf_norm) |
                       ((det_idx_q == 2'd3) && !den_cull && (den_q == '0));
          if ((det_idx_q == 2'd3) && den_cull) miss_q <= 1'b1;
        end
        ST_DIV: if (div_done) begin
          unique case (div_sel_q)
            2'd0:    qa_q <= div_q;
            2'd1:    qb_q <= div_q;
            default: qt_q <= div_q;
          endcase
          div_sel_q <= div_sel_q + 2'd1;
          invalid_q <= invalid_q | div_ovf;
        end
        ST_CHK: begin
          o_hit     <= hit_d;
          o_invalid <= invalid_q;
          o_t       <= hit_d ? qt_q : '0;
          o_normal  <= hit_d ? normal_q : '0;
          o_id      <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_tri_intersect_seq.sv
// Directed bench for ray_tri_intersect_seq: one instance without culling,
// one with back-face culling, sharing clock, reset and operand buses.
module tb_ray_tri_intersect_seq;

  localparam int W = 32;
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] QTR  = 32'h0000_4000;
  localparam logic [W-1:0] TQTR = 32'h0000_C000;
  localparam logic [W-1:0] NONE = 32'hFFFF_0000;
  localparam logic [W-1:0] ZERO = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic valid_a, ready_a, valid_c, ready_c;
  logic [0:2][0:2][W-1:0] tri_in;
  logic [0:1][0:2][W-1:0] ray_in;
  logic [7:0] id_in;

  logic ordy_a, ov_a, hit_a, inv_a;
  logic [W-1:0] t_a;
  logic [0:2][W-1:0] nrm_a;
  logic [7:0] oid_a;
  logic ordy_c, ov_c, hit_c, inv_c;
  logic [W-1:0] t_c;
  logic [0:2][W-1:0] nrm_c;
  logic [7:0] oid_c;

  ray_tri_intersect_seq #(.W(32), .F(16), .ID_W(8), .CULL_BACKFACE(1'b0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(ordy_a),
    .i_triangle(tri_in), .i_ray(ray_in), .i_id(id_in), .o_valid(ov_a),
    .i_ready(ready_a), .o_hit(hit_a), .o_invalid(inv_a), .o_t(t_a),
    .o_normal(nrm_a), .o_id(oid_a));

  ray_tri_intersect_seq #(.W(32), .F(16), .ID_W(8), .CULL_BACKFACE(1'b1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_c), .o_ready(ordy_c),
    .i_triangle(tri_in), .i_ray(ray_in), .i_id(id_in), .o_valid(ov_c),
    .i_ready(ready_c), .o_hit(hit_c), .o_invalid(inv_c), .o_t(t_c),
    .o_normal(nrm_c), .o_id(oid_c));

  int checks = 0;
  int failures = 0;
  int lat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_scene(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic [W-1:0] ez,
                           input logic [W-1:0] dx, input logic [W-1:0] dy, input logic [W-1:0] dz,
                           input logic [7:0] id);
    tri_in       = '0;
    tri_in[1][0] = ONE;
    tri_in[2][1] = ONE;
    ray_in[0]    = {ex, ey, ez};
    ray_in[1]    = {dx, dy, dz};
    id_in        = id;
  endtask

  // Accept one pair on the chosen instance and count edges until o_valid.
  task automatic run_txn(input bit use_c, output int cycles);
    @(negedge clk);
    if (use_c) valid_c = 1'b1;
    else       valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_c = 1'b0;
    cycles = 0;
    while (!(use_c ? ov_c : ov_a) && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic release_out(input bit use_c);
    @(negedge clk);
    if (use_c) ready_c = 1'b1;
    else       ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    ready_c = 1'b0;
    chk("release_valid", 128'(use_c ? ov_c : ov_a), 128'(1'b0));
    chk("release_ready", 128'(use_c ? ordy_c : ordy_a), 128'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_a = 1'b0; ready_a = 1'b0; valid_c = 1'b0; ready_c = 1'b0;
    set_scene(ZERO, ZERO, ZERO, ZERO, ZERO, ZERO, 8'h00);
    #12;
    chk("rst_ready",   128'(ordy_a), 128'(1'b1));
    chk("rst_valid",   128'(ov_a),   128'(1'b0));
    chk("rst_hit",     128'(hit_a),  128'(1'b0));
    chk("rst_invalid", 128'(inv_a),  128'(1'b0));
    chk("rst_t",       128'(t_a),    128'(0));
    chk("rst_normal",  128'(nrm_a),  128'(0));
    chk("rst_id",      128'(oid_a),  128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Centre hit, then backpressure with a competing i_valid.
    set_scene(QTR, QTR, ONE, ZERO, ZERO, NONE, 8'h11);
    run_txn(1'b0, lat);
    chk("centre_lat",     128'(lat),   128'(153));
    chk("centre_hit",     128'(hit_a), 128'(1'b1));
    chk("centre_invalid", 128'(inv_a), 128'(1'b0));
    chk("centre_t",       128'(t_a),   128'(ONE));
    chk("centre_normal",  128'(nrm_a), 128'({ZERO, ZERO, ONE}));
    chk("centre_id",      128'(oid_a), 128'(8'h11));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_scene(TQTR, TQTR, ONE, ZERO, ZERO, NONE, 8'h22);
      valid_a = 1'b1;
      chk("hold_valid", 128'(ov_a),   128'(1'b1));
      chk("hold_ready", 128'(ordy_a), 128'(1'b0));
      chk("hold_hit",   128'(hit_a),  128'(1'b1));
      chk("hold_t",     128'(t_a),    128'(ONE));
      chk("hold_id",    128'(oid_a),  128'(8'h11));
    end
    @(negedge clk);
    valid_a = 1'b0;
    release_out(1'b0);
    @(negedge clk);
    chk("ignored_valid", 128'(ov_a),   128'(1'b0));
    chk("ignored_ready", 128'(ordy_a), 128'(1'b1));

    // Outside: a+b = 1.5.
    set_scene(TQTR, TQTR, ONE, ZERO, ZERO, NONE, 8'h33);
    run_txn(1'b0, lat);
    chk("outside_lat",     128'(lat),   128'(153));
    chk("outside_hit",     128'(hit_a), 128'(1'b0));
    chk("outside_invalid", 128'(inv_a), 128'(1'b0));
    chk("outside_t",       128'(t_a),   128'(0));
    chk("outside_normal",  128'(nrm_a), 128'(0));
    chk("outside_id",      128'(oid_a), 128'(8'h33));
    release_out(1'b0);

    // Parallel ray: den = 0.
    set_scene(QTR, QTR, ONE, ONE, ZERO, ZERO, 8'h44);
    run_txn(1'b0, lat);
    chk("parallel_lat",     128'(lat),   128'(6));
    chk("parallel_invalid", 128'(inv_a), 128'(1'b1));
    chk("parallel_hit",     128'(hit_a), 128'(1'b0));
    chk("parallel_t",       128'(t_a),   128'(0));
    chk("parallel_normal",  128'(nrm_a), 128'(0));
    chk("parallel_id",      128'(oid_a), 128'(8'h44));
    release_out(1'b0);

    // Back face with culling: clean miss on the short path.
    set_scene(QTR, QTR, ONE, ZERO, ZERO, ONE, 8'h55);
    run_txn(1'b1, lat);
    chk("cull_lat",     128'(lat),   128'(6));
    chk("cull_hit",     128'(hit_c), 128'(1'b0));
    chk("cull_invalid", 128'(inv_c), 128'(1'b0));
    chk("cull_t",       128'(t_c),   128'(0));
    chk("cull_id",      128'(oid_c), 128'(8'h55));
    release_out(1'b1);

    // Back face without culling: t = -1.0, a,b negative -> miss.
    set_scene(QTR, QTR, ONE, ZERO, ZERO, ONE, 8'h66);
    run_txn(1'b0, lat);
    chk("back_lat",     128'(lat),   128'(153));
    chk("back_hit",     128'(hit_a), 128'(1'b0));
    chk("back_invalid", 128'(inv_a), 128'(1'b0));
    chk("back_t",       128'(t_a),   128'(0));
    chk("back_id",      128'(oid_a), 128'(8'h66));
    release_out(1'b0);

    // Reset during DIV aborts the transaction.
    set_scene(QTR, QTR, ONE, ZERO, ZERO, NONE, 8'h70);
    @(negedge clk);
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (55) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(ov_a),   128'(1'b0));
    chk("abort_ready", 128'(ordy_a), 128'(1'b1));
    chk("abort_t",     128'(t_a),    128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    set_scene(QTR, QTR, ONE, ZERO, ZERO, NONE, 8'h77);
    run_txn(1'b0, lat);
    chk("after_rst_lat",    128'(lat),   128'(153));
    chk("after_rst_hit",    128'(hit_a), 128'(1'b1));
    chk("after_rst_t",      128'(t_a),   128'(ONE));
    chk("after_rst_normal", 128'(nrm_a), 128'({ZERO, ZERO, ONE}));
    chk("after_rst_id",     128'(oid_a), 128'(8'h77));
    release_out(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
